// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   pcsrc encoding driven by main_decoder and consumed by fetch_unit/next_pc_mux.
//   fetch_state_t : state encoding of the fetch_unit FSM.
package cpu_pkg;

  localparam logic [1:0] PCSRC_PLUS4   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH  = 2'b01;
  localparam logic [1:0] PCSRC_JALR    = 2'b10;
  localparam logic [1:0] PCSRC_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection.
// Ports:
//   pc        in  32  address of the current instruction
//   pcsrc     in  2   next-PC select (see cpu_pkg PCSRC_*)
//   immext    in  32  sign-extended immediate
//   aluresult in  32  jalr target from the ALU
//   nextpc    out 32  selected next PC (sums wrap modulo 2^32)
//   pcplus4   out 32  pc + 4
//   illegal   out 1   pcsrc is illegal or the selected target is not word aligned
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] immext,
  input  logic [31:0] aluresult,
  output logic [31:0] nextpc,
  output logic [31:0] pcplus4,
  output logic        illegal
);

  assign pcplus4 = pc + 32'd4;

  always_comb begin
    nextpc = pcplus4;
    case (pcsrc)
      PCSRC_PLUS4:  nextpc = pcplus4;
      PCSRC_BRANCH: nextpc = pc + immext;
      // jalr clears bit 0 of the target
      PCSRC_JALR:   nextpc = aluresult & 32'hFFFF_FFFE;
      default:      nextpc = pcplus4;
    endcase
    // bit 1 set means a half-word target; handled the same as an illegal pcsrc
    illegal = (pcsrc == PCSRC_ILLEGAL) || nextpc[1];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests an instruction word at pc, holds it until
// commit, then advances pc according to pcsrc.
// Optional build macro: FETCH_TRAP_EN -- illegal/misaligned commits redirect
// to TRAP_PC with a one-cycle trap pulse instead of halting.
// Ports:
//   clk         in  1   clock, rising edge
//   rst         in  1   synchronous active-high reset
//   pcsrc       in  2   next-PC select, valid with commit
//   immext      in  32  sign-extended immediate, valid with commit
//   aluresult   in  32  jalr target, valid with commit
//   commit      in  1   current instruction retires this cycle
//   imem_req    out 1   instruction memory request
//   imem_addr   out 32  request address
//   imem_ack    in  1   memory returns data this cycle
//   imem_rdata  in  32  instruction word, valid with imem_ack
//   instr       out 32  held instruction
//   pc          out 32  address of instr
//   pcplus4     out 32  pc + 4 for link writeback
//   instrvalid  out 1   instr/pc valid and awaiting commit
//   trap        out 1   one-cycle trap pulse (0 without FETCH_TRAP_EN)
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// READY | instr held, waiting for commit
// HALT  | stopped after illegal commit, left only by rst
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] immext,
  input  logic [31:0] aluresult,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instrvalid,
  output logic        trap
);

  // Redirect targets are fetch addresses and must be word aligned.
  if ((RESET_PC[1:0] != 2'b00) || (TRAP_PC[1:0] != 2'b00)) begin : g_align_check
    $error("fetch_unit: RESET_PC and TRAP_PC must be word aligned");
  end

  fetch_state_t state, state_next;
  logic [31:0]  pc_next, instr_next, nextpc;
  logic         illegal;

  next_pc_mux u_next_pc_mux (
    .pc        (pc),
    .pcsrc     (pcsrc),
    .immext    (immext),
    .aluresult (aluresult),
    .nextpc    (nextpc),
    .pcplus4   (pcplus4),
    .illegal   (illegal)
  );

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign instrvalid = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
    end
  end

`ifdef FETCH_TRAP_EN
  logic trap_next;

  always_ff @(posedge clk) begin
    if (rst) trap <= 1'b0;
    else     trap <= trap_next;
  end
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
`ifdef FETCH_TRAP_EN
    trap_next  = 1'b0;
`endif
    case (state)
      FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = READY;
        end
      end
      READY: begin
        if (commit) begin
          if (illegal) begin
`ifdef FETCH_TRAP_EN
            pc_next    = TRAP_PC;
            trap_next  = 1'b1;
            state_next = FETCH;
`else
            state_next = HALT;
`endif
          end else begin
            pc_next    = nextpc;
            state_next = FETCH;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

endmodule
